// File: rtl/vga_pixel_aligner.sv
// Buffers a pixel stream in a small FWFT FIFO and locks it to the VGA raster at
// frame start; pixels leave registered and aligned with the 1-cycle delayed syncs.
module vga_pixel_aligner #(
  parameter int unsigned DW      = 24,
  parameter int unsigned FIFO_AW = 4,
  parameter int unsigned HSZ     = 10,
  parameter int unsigned VSZ     = 9,
  parameter int unsigned H_RES   = 640,
  parameter int unsigned V_RES   = 480
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic [DW-1:0]  s_data_i,
  input  logic           s_valid_i,
  input  logic           s_sof_i,
  input  logic           s_eol_i,
  output logic           s_ready_o,
  input  logic [HSZ-1:0] hcount_i,
  input  logic [VSZ-1:0] vcount_i,
  input  logic           de_i,
  input  logic           hsync_i,
  input  logic           vsync_i,
  output logic [DW-1:0]  rgb_o,
  output logic           de_o,
  output logic           hsync_o,
  output logic           vsync_o,
  output logic           locked_o,
  output logic           underflow_o,
  output logic [7:0]     err_count_o
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;

  if (H_RES > (1 << HSZ) || V_RES > (1 << VSZ)) begin : g_cfg_check
    $error("vga_pixel_aligner: H_RES/V_RES do not fit the position counter widths");
  end

  typedef enum logic [1:0] {WAIT_SOF, ARMED, RUN} state_t;

  state_t state, state_next;

  logic [DW+1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full, empty, wr_en, rd_en;
  logic               head_sof, head_eol;
  logic [DW-1:0]      head_data;
  logic               fs, last_px, fault, pop, emit;

  // FIFO storage and pointers
  assign full      = (count == (FIFO_AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign s_ready_o = !full;
  assign wr_en     = s_valid_i && !full;
  assign rd_en     = pop && !empty;

  assign {head_sof, head_eol, head_data} = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= {s_sof_i, s_eol_i, s_data_i};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Raster qualifiers and lock-loss detection
  assign fs      = de_i && (hcount_i == '0) && (vcount_i == '0);
  assign last_px = (hcount_i == HSZ'(H_RES - 1));

  always_comb begin
    fault = 1'b0;
    if (state == RUN && de_i) begin
      if (empty) fault = 1'b1;
      else       fault = (head_sof != fs) || (head_eol != last_px);
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= WAIT_SOF;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      WAIT_SOF: if (!empty && head_sof) state_next = ARMED;
      ARMED:    if (fs && !empty)       state_next = RUN;
      RUN:      if (fault)              state_next = WAIT_SOF;
      default:                          state_next = WAIT_SOF;
    endcase
  end

  // Pop/emit decisions; a faulting sof entry stays at the head so the
  // discard phase can re-arm on it without losing the frame start.
  always_comb begin
    pop  = 1'b0;
    emit = 1'b0;
    case (state)
      WAIT_SOF: pop = !empty && !head_sof;
      ARMED: begin
        if (fs && !empty) begin
          pop  = 1'b1;
          emit = 1'b1;
        end
      end
      RUN: begin
        if (de_i) begin
          emit = !fault;
          pop  = !empty && !(fault && head_sof);
        end
      end
      default: begin
        pop  = 1'b0;
        emit = 1'b0;
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rgb_o       <= '0;
      de_o        <= 1'b0;
      hsync_o     <= 1'b1;
      vsync_o     <= 1'b1;
      locked_o    <= 1'b0;
      underflow_o <= 1'b0;
      err_count_o <= '0;
    end else begin
      rgb_o       <= emit ? head_data : '0;
      de_o        <= de_i;
      hsync_o     <= hsync_i;
      vsync_o     <= vsync_i;
      locked_o    <= (state_next == RUN);
      underflow_o <= fault;
      if (fault && err_count_o != '1) err_count_o <= err_count_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_pixel_aligner.sv
// Directed bench for vga_pixel_aligner on a shrunken 8x4 raster (12x6 total);
// pixel data is {frame, y, x} so misplaced, lost or repeated pixels are visible.
module tb_vga_pixel_aligner;

  localparam int DW = 24, FIFO_AW = 4, HSZ = 4, VSZ = 3;
  localparam int H_RES = 8, V_RES = 4, H_TOT = 12, V_TOT = 6;

  logic           clk_i = 1'b0;
  logic           rst_n_i;
  logic [DW-1:0]  s_data_i;
  logic           s_valid_i, s_sof_i, s_eol_i, s_ready_o;
  logic [HSZ-1:0] hcount_i;
  logic [VSZ-1:0] vcount_i;
  logic           de_i, hsync_i, vsync_i;
  logic [DW-1:0]  rgb_o;
  logic           de_o, hsync_o, vsync_o, locked_o, underflow_o;
  logic [7:0]     err_count_o;

  vga_pixel_aligner #(
    .DW(DW), .FIFO_AW(FIFO_AW), .HSZ(HSZ), .VSZ(VSZ), .H_RES(H_RES), .V_RES(V_RES)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_sof_i(s_sof_i), .s_eol_i(s_eol_i),
    .s_ready_o(s_ready_o),
    .hcount_i(hcount_i), .vcount_i(vcount_i), .de_i(de_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .rgb_o(rgb_o), .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .locked_o(locked_o), .underflow_o(underflow_o), .err_count_o(err_count_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, errors = 0;

  // raster and producer state
  int         hcnt, vcnt, px, py, junk_left, short_y;
  logic [7:0] pf, short_f;
  bit         prod_en;
  int         prev_h, prev_v;
  logic       prev_de, prev_hs, prev_vs;

  // expected-behaviour state
  bit         exp_lock, fault_on, exp_uf;
  logic [7:0] exp_frame, fault_f;
  int         exp_err, fault_x, fault_y;
  logic [DW-1:0] exp_rgb;

  // One pixel clock: drive raster + stream, step past the edge, advance counters.
  task automatic cycle();
    bit acc;
    int le;
    le = (py == short_y && pf == short_f) ? H_RES - 2 : H_RES - 1;
    hcount_i  = HSZ'(hcnt);
    vcount_i  = VSZ'(vcnt);
    de_i      = (hcnt < H_RES) && (vcnt < V_RES);
    hsync_i   = !(hcnt == H_RES + 1 || hcnt == H_RES + 2);
    vsync_i   = !(vcnt == V_RES + 1);
    s_valid_i = prod_en;
    if (junk_left > 0) begin
      s_data_i = {8'hEE, 8'h00, 8'(junk_left)};
      s_sof_i  = 1'b0;
      s_eol_i  = 1'b0;
    end else begin
      s_data_i = {pf, 8'(py), 8'(px)};
      s_sof_i  = (px == 0 && py == 0);
      s_eol_i  = (px == le);
    end
    acc = prod_en && s_ready_o;
    @(posedge clk_i);
    #1;
    prev_h = hcnt; prev_v = vcnt; prev_de = de_i; prev_hs = hsync_i; prev_vs = vsync_i;
    if (acc) begin
      if (junk_left > 0) junk_left--;
      else if (px == le) begin
        px = 0;
        if (py == V_RES - 1) begin py = 0; pf++; end
        else py++;
      end else px++;
    end
    if (hcnt == H_TOT - 1) begin
      hcnt = 0;
      vcnt = (vcnt == V_TOT - 1) ? 0 : vcnt + 1;
    end else hcnt++;
  endtask

  // Expected outputs for the cycle just clocked: lock at every frame start,
  // frame tag advances per frame, a planned fault blanks the pixel and drops lock.
  task automatic expect_step();
    bit fs;
    fs = prev_de && prev_h == 0 && prev_v == 0;
    exp_rgb = '0;
    exp_uf  = 1'b0;
    if (fs) begin
      exp_frame++;
      exp_lock = 1'b1;
    end
    if (exp_lock && prev_de) begin
      if (fault_on && prev_h == fault_x && prev_v == fault_y && exp_frame == fault_f) begin
        exp_uf = 1'b1; exp_lock = 1'b0; exp_err++; fault_on = 1'b0;
      end else exp_rgb = {exp_frame, 8'(prev_v), 8'(prev_h)};
    end
  endtask

  task automatic reset_dut(input logic [7:0] pf0);
    rst_n_i = 1'b0; prod_en = 1'b0; junk_left = 0; short_y = -1; short_f = 8'd0;
    px = 0; py = 0; pf = pf0; hcnt = 0; vcnt = V_RES;
    exp_lock = 1'b0; exp_frame = pf0 - 8'd1; exp_err = 0; fault_on = 1'b0;
    repeat (2) cycle();
    hcnt = 0; vcnt = V_RES;
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; de_i = 1'b1; hsync_i = 1'b0; vsync_i = 1'b0;
    s_valid_i = 1'b1; s_sof_i = 1'b1; s_eol_i = 1'b0; s_data_i = 24'h123456;
    hcount_i = '0; vcount_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if (rgb_o !== 24'h0)       begin errors++; $display("FAIL reset_rgb got %h expected 0", rgb_o); end
    checks++; if (de_o !== 1'b0)         begin errors++; $display("FAIL reset_de got %b expected 0", de_o); end
    checks++; if (hsync_o !== 1'b1)      begin errors++; $display("FAIL reset_hsync got %b expected 1", hsync_o); end
    checks++; if (vsync_o !== 1'b1)      begin errors++; $display("FAIL reset_vsync got %b expected 1", vsync_o); end
    checks++; if (locked_o !== 1'b0)     begin errors++; $display("FAIL reset_locked got %b expected 0", locked_o); end
    checks++; if (underflow_o !== 1'b0)  begin errors++; $display("FAIL reset_underflow got %b expected 0", underflow_o); end
    checks++; if (err_count_o !== 8'd0)  begin errors++; $display("FAIL reset_err_count got %0d expected 0", err_count_o); end
    checks++; if (s_ready_o !== 1'b1)    begin errors++; $display("FAIL reset_ready got %b expected 1", s_ready_o); end
  endtask

  // Preloaded ramp over two frames with the FIFO kept full by the producer.
  task automatic test_ramp();
    int ready_low;
    ready_low = 0;
    reset_dut(8'd0);
    prod_en = 1'b1;
    for (int c = 0; c < 24 + 2 * 72; c++) begin
      cycle();
      expect_step();
      if (c == 23) begin
        checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL ramp_preload_full got ready=%b expected 0", s_ready_o); end
      end
      if (c >= 24 && !s_ready_o) ready_low++;
      checks++; if (rgb_o !== exp_rgb) begin errors++; $display("FAIL ramp_rgb c=%0d got %h expected %h", c, rgb_o, exp_rgb); end
      checks++; if ({de_o, hsync_o, vsync_o} !== {prev_de, prev_hs, prev_vs})
        begin errors++; $display("FAIL ramp_syncs c=%0d got %b expected %b", c, {de_o, hsync_o, vsync_o}, {prev_de, prev_hs, prev_vs}); end
      checks++; if (locked_o !== exp_lock) begin errors++; $display("FAIL ramp_locked c=%0d got %b expected %b", c, locked_o, exp_lock); end
      checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL ramp_underflow c=%0d got %b expected 0", c, underflow_o); end
    end
    checks++; if (err_count_o !== 8'd0) begin errors++; $display("FAIL ramp_err_count got %0d expected 0", err_count_o); end
    checks++; if (ready_low == 0) begin errors++; $display("FAIL ramp_ready_toggle got %0d low cycles expected >0", ready_low); end
  endtask

  // Non-sof garbage ahead of a proper frame must be discarded before lock.
  task automatic test_junk();
    reset_dut(8'd5);
    junk_left = 12;
    prod_en = 1'b1;
    for (int c = 0; c < 24 + 72; c++) begin
      cycle();
      expect_step();
      if (c == 24) begin
        checks++; if (rgb_o !== 24'h050000) begin errors++; $display("FAIL junk_first_pixel got %h expected 050000", rgb_o); end
      end
      checks++; if (rgb_o !== exp_rgb) begin errors++; $display("FAIL junk_rgb c=%0d got %h expected %h", c, rgb_o, exp_rgb); end
      checks++; if (locked_o !== exp_lock) begin errors++; $display("FAIL junk_locked c=%0d got %b expected %b", c, locked_o, exp_lock); end
      checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL junk_underflow c=%0d got %b expected 0", c, underflow_o); end
    end
    checks++; if (err_count_o !== 8'd0) begin errors++; $display("FAIL junk_err_count got %0d expected 0", err_count_o); end
  endtask

  // Producer stalls mid-line; the first unsent pixel's slot must underflow.
  task automatic test_underflow();
    int pulses;
    pulses = 0;
    reset_dut(8'd8);
    prod_en = 1'b1;
    for (int c = 0; c < 24 + 3 * 72; c++) begin
      if (c == 39) begin
        prod_en = 1'b0; fault_on = 1'b1; fault_x = px; fault_y = py; fault_f = pf;
      end
      if (c == 79) prod_en = 1'b1;
      cycle();
      expect_step();
      if (underflow_o === 1'b1) pulses++;
      checks++; if (rgb_o !== exp_rgb) begin errors++; $display("FAIL uflow_rgb c=%0d got %h expected %h", c, rgb_o, exp_rgb); end
      checks++; if (locked_o !== exp_lock) begin errors++; $display("FAIL uflow_locked c=%0d got %b expected %b", c, locked_o, exp_lock); end
      checks++; if (underflow_o !== exp_uf) begin errors++; $display("FAIL uflow_pulse c=%0d got %b expected %b", c, underflow_o, exp_uf); end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL uflow_pulse_count got %0d expected 1", pulses); end
    checks++; if (err_count_o !== 8'd1) begin errors++; $display("FAIL uflow_err_count got %0d expected 1", err_count_o); end
    checks++; if (locked_o !== 1'b1) begin errors++; $display("FAIL uflow_relock got %b expected 1", locked_o); end
  endtask

  // Line 1 of frame tag 3 is one pixel short: its eol lands at hcount 6.
  task automatic test_early_eol();
    reset_dut(8'd3);
    short_y = 1; short_f = 8'd3;
    fault_on = 1'b1; fault_x = H_RES - 2; fault_y = 1; fault_f = 8'd3;
    prod_en = 1'b1;
    for (int c = 0; c < 24 + 3 * 72; c++) begin
      cycle();
      expect_step();
      checks++; if (rgb_o !== exp_rgb) begin errors++; $display("FAIL eol_rgb c=%0d got %h expected %h", c, rgb_o, exp_rgb); end
      checks++; if (locked_o !== exp_lock) begin errors++; $display("FAIL eol_locked c=%0d got %b expected %b", c, locked_o, exp_lock); end
      checks++; if (underflow_o !== exp_uf) begin errors++; $display("FAIL eol_underflow c=%0d got %b expected %b", c, underflow_o, exp_uf); end
    end
    checks++; if (err_count_o !== 8'd1) begin errors++; $display("FAIL eol_err_count got %0d expected 1", err_count_o); end
  endtask

  // Continues from the locked, err_count=1 state left by test_early_eol.
  task automatic test_mid_reset();
    for (int c = 0; c < 16; c++) begin
      cycle();
      expect_step();
      checks++; if (rgb_o !== exp_rgb) begin errors++; $display("FAIL mrst_pre_rgb c=%0d got %h expected %h", c, rgb_o, exp_rgb); end
      checks++; if (de_o !== prev_de) begin errors++; $display("FAIL mrst_pre_de c=%0d got %b expected %b", c, de_o, prev_de); end
      checks++; if (locked_o !== exp_lock) begin errors++; $display("FAIL mrst_pre_locked c=%0d got %b expected %b", c, locked_o, exp_lock); end
    end
    #2;
    rst_n_i = 1'b0;
    #1;
    checks++; if (rgb_o !== 24'h0)      begin errors++; $display("FAIL mrst_rgb got %h expected 0", rgb_o); end
    checks++; if (de_o !== 1'b0)        begin errors++; $display("FAIL mrst_de got %b expected 0", de_o); end
    checks++; if (locked_o !== 1'b0)    begin errors++; $display("FAIL mrst_locked got %b expected 0", locked_o); end
    checks++; if (err_count_o !== 8'd0) begin errors++; $display("FAIL mrst_err_count got %0d expected 0", err_count_o); end
    checks++; if ({hsync_o, vsync_o} !== 2'b11) begin errors++; $display("FAIL mrst_syncs got %b expected 11", {hsync_o, vsync_o}); end
    prod_en = 1'b0; junk_left = 0; short_y = -1; px = 0; py = 0; pf = 8'd9;
    exp_lock = 1'b0; exp_frame = 8'd8; exp_err = 0; fault_on = 1'b0;
    repeat (2) cycle();
    rst_n_i = 1'b1;
    prod_en = 1'b1;
    for (int c = 0; c < 72 + 60; c++) begin
      cycle();
      expect_step();
      checks++; if (rgb_o !== exp_rgb) begin errors++; $display("FAIL mrst_rgb_after c=%0d got %h expected %h", c, rgb_o, exp_rgb); end
      checks++; if (locked_o !== exp_lock) begin errors++; $display("FAIL mrst_locked_after c=%0d got %b expected %b", c, locked_o, exp_lock); end
      checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL mrst_underflow c=%0d got %b expected 0", c, underflow_o); end
    end
    checks++; if (locked_o !== 1'b1) begin errors++; $display("FAIL mrst_relock got %b expected 1", locked_o); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_junk();
    test_underflow();
    test_early_eol();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
